// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the level-tracking FIFO (fifo_lvl).
package fifo_pkg;

  // Decoded accepted operation for one cycle, encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Default address width used when the FIFO is not overridden.
  localparam int DEF_W = 4;
  localparam int DEPTH = 2 ** DEF_W;

  // Level counter width: one extra bit so a full FIFO (2**w) is representable.
  function automatic int lvl_w(input int w);
    return w + 1;
  endfunction

  // Number of entries for a given address width.
  function automatic int depth_of(input int w);
    return 2 ** w;
  endfunction

endpackage

// File: rtl/fifo_lvl_ctrl.sv
// Pointer, level and flag control for fifo_lvl. Flags are registered from the
// next-state level so they always agree with level. Error flags only exist when
// FIFO_LVL_ERR_EN is defined.
module fifo_lvl_ctrl
  import fifo_pkg::*;
#(
  parameter int W     = 4,
  parameter int AF_TH = 14,
  parameter int AE_TH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         rd,
`ifdef FIFO_LVL_ERR_EN
  input  logic         clr_err,
  output logic         overflow,
  output logic         underflow,
`endif
  output logic         wa,
  output logic [W-1:0] wptr,
  output logic [W-1:0] rptr,
  output logic [W:0]   level,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty
);

  localparam int LW = lvl_w(W);
  localparam logic [LW-1:0] DEPTH_L = LW'(depth_of(W));
  localparam logic [LW-1:0] AF_L    = LW'(AF_TH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_TH);

  logic          ra;
  op_e           op;
  logic [LW-1:0] lvl_n;

  // Acceptance and next-level decode. A write at full is accepted only when a
  // read frees the head slot in the same cycle.
  always_comb begin
    ra    = rd & ~empty;
    wa    = wr & (~full | rd);
    op    = op_e'({wa, ra});
    lvl_n = level;
    case (op)
      OP_PUSH: lvl_n = level + LW'(1);
      OP_POP:  lvl_n = level - LW'(1);
      default: lvl_n = level;
    endcase
  end

  // Pointers, level and registered flags; pointers wrap modulo 2**W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wa) wptr <= wptr + W'(1);
      if (ra) rptr <= rptr + W'(1);
      level        <= lvl_n;
      full         <= (lvl_n == DEPTH_L);
      empty        <= (lvl_n == '0);
      almost_full  <= (lvl_n >= AF_L);
      almost_empty <= (lvl_n <= AE_L);
    end
  end

`ifdef FIFO_LVL_ERR_EN
  // Sticky error flags; a set event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr & full & ~rd) | (overflow & ~clr_err);
      underflow <= (rd & empty) | (underflow & ~clr_err);
    end
  end
`endif

endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: parametrised first-word-fall-through FIFO with occupancy level and
// almost-full/almost-empty thresholds. Optional sticky overflow/underflow flags
// with clr_err are enabled by defining FIFO_LVL_ERR_EN.
module fifo_lvl
  import fifo_pkg::*;
#(
  parameter int B     = 8,
  parameter int W     = 4,
  parameter int AF_TH = 2 ** W - 2,
  parameter int AE_TH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] wdata,
`ifdef FIFO_LVL_ERR_EN
  input  logic         clr_err,
  output logic         overflow,
  output logic         underflow,
`endif
  output logic [B-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   level
);

  // Reject illegal configurations at elaboration.
  if (W < 1 || AE_TH >= AF_TH || AF_TH > 2 ** W) begin : g_bad_cfg
    $error("fifo_lvl: illegal parameters W=%0d AF_TH=%0d AE_TH=%0d", W, AF_TH, AE_TH);
  end

  logic [B-1:0] mem [depth_of(W)];
  logic [W-1:0] wptr;
  logic [W-1:0] rptr;
  logic         wa;

  fifo_lvl_ctrl #(
    .W     (W),
    .AF_TH (AF_TH),
    .AE_TH (AE_TH)
  ) u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (wr),
    .rd           (rd),
`ifdef FIFO_LVL_ERR_EN
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .wa           (wa),
    .wptr         (wptr),
    .rptr         (rptr),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // Storage write; the array is intentionally not reset, stale data is unreachable.
  always_ff @(posedge clk) begin
    if (wa) mem[wptr] <= wdata;
  end

  // Head of queue is presented combinationally (first-word-fall-through).
  always_comb begin
    rdata = mem[rptr];
  end

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed self-checking bench for fifo_lvl with B=8, W=2, AF_TH=3, AE_TH=1.
// Error-flag checks are included when FIFO_LVL_ERR_EN is defined.
module tb_fifo_lvl;

  logic       clk;
  logic       reset_n;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] level;
`ifdef FIFO_LVL_ERR_EN
  logic       clr_err;
  logic       overflow;
  logic       underflow;
`endif

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  fifo_lvl #(
    .B     (8),
    .W     (2),
    .AF_TH (3),
    .AE_TH (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (wr),
    .rd           (rd),
    .wdata        (wdata),
`ifdef FIFO_LVL_ERR_EN
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr = 1'b1; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic both(input logic [7:0] d);
    wr = 1'b1; rd = 1'b1; wdata = d;
    tick();
    wr = 1'b0; rd = 1'b0;
  endtask

  // Check head data, then pop it.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check(tag, rdata, exp);
    pop();
  endtask

  task automatic flags(input string tag, input logic [2:0] lv, input logic e, input logic f,
                       input logic ae, input logic af);
    check({tag, ".level"}, level, lv);
    check({tag, ".empty"}, empty, e);
    check({tag, ".full"}, full, f);
    check({tag, ".ae"}, almost_empty, ae);
    check({tag, ".af"}, almost_full, af);
  endtask

`ifdef FIFO_LVL_ERR_EN
  task automatic clear_err();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr = 1'b0; rd = 1'b0; wdata = 8'h00; reset_n = 1'b0;
`ifdef FIFO_LVL_ERR_EN
    clr_err = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    flags("rst", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FIFO_LVL_ERR_EN
    check("rst.ovf", overflow, 1'b0);
    check("rst.udf", underflow, 1'b0);
`endif
    reset_n = 1'b1;
    tick();

    // 1: fill to full, then rejected push
    push(8'hA1); flags("t1.l1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1.head", rdata, 8'hA1);
    push(8'hA2); flags("t1.l2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'hA3); flags("t1.l3", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    push(8'hA4); flags("t1.l4", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    push(8'hA5); flags("t1.drop", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t1.head2", rdata, 8'hA1);
`ifdef FIFO_LVL_ERR_EN
    check("t1.ovf", overflow, 1'b1);
`endif

    // 2: drain in order, then rejected pop
    pop_chk("t2.d0", 8'hA1); check("t2.lv3", level, 3'd3);
    pop_chk("t2.d1", 8'hA2); check("t2.lv2", level, 3'd2);
    pop_chk("t2.d2", 8'hA3); check("t2.lv1", level, 3'd1);
    pop_chk("t2.d3", 8'hA4);
    flags("t2.empty", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    pop(); check("t2.uflv", level, 3'd0);
`ifdef FIFO_LVL_ERR_EN
    check("t2.udf", underflow, 1'b1);
    clear_err();
    check("t2.clr.ovf", overflow, 1'b0);
    check("t2.clr.udf", underflow, 1'b0);
`endif

    // 3: wr&rd at empty -> write only
    both(8'h55);
    flags("t3", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3.rdata", rdata, 8'h55);
`ifdef FIFO_LVL_ERR_EN
    check("t3.udf", underflow, 1'b1);
    clear_err();
    check("t3.clr", underflow, 1'b0);
`endif
    pop_chk("t3.pop", 8'h55);
    check("t3.lv0", level, 3'd0);

    // 4: wr&rd at full -> both accepted
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    both(8'h77);
    flags("t4", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_LVL_ERR_EN
    check("t4.ovf", overflow, 1'b0);
`endif
    pop_chk("t4.d0", 8'hA2);
    pop_chk("t4.d1", 8'hA3);
    pop_chk("t4.d2", 8'hA4);
    pop_chk("t4.d3", 8'h77);
    check("t4.empty", empty, 1'b1);

    // 5: wrap-around, push then pop through a scoreboard queue
    for (int i = 8'h10; i <= 8'h19; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i));
      check("t5.lv1", level, 3'd1);
      pop_chk("t5.data", exp_q.pop_front());
      check("t5.lv0", level, 3'd0);
    end

    // 6: asynchronous reset mid-cycle
`ifdef FIFO_LVL_ERR_EN
    pop();
    check("t6.udf", underflow, 1'b1);
`endif
    push(8'hB1); push(8'hB2); push(8'hB3);
    check("t6.lv3", level, 3'd3);
    #2 reset_n = 1'b0;
    #1;
    flags("t6.rst", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FIFO_LVL_ERR_EN
    check("t6.rst.udf", underflow, 1'b0);
    check("t6.rst.ovf", overflow, 1'b0);
`endif
    #3 reset_n = 1'b1;
    push(8'hC3);
    check("t6.rdata", rdata, 8'hC3);
    check("t6.lv1", level, 3'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
